next_pc_unit: RTL
=================

# next_pc_unit

Program-counter sequencing stage that sits directly downstream of the branch comparator. It owns the architectural PC and advances it by a fixed increment on each completed instruction. On a branch it waits one cycle for the comparator's registered `isBranch` decision, then either loads the captured target or falls through. It also provides halt handling and optional taken/not-taken statistics.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `PC_INC`, 4, fall-through increment in bytes.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  pulse; leaves IDLE and begins sequencing.
- `step`  input  1  pulse; the current non-branch instruction has completed.
- `brIssue`  input  1  pulse; a branch has been issued to the comparator this cycle.
- `brTarget`  input  32  absolute branch target; sampled when `brIssue` is accepted.
- `isBranch`  input  1  comparator decision; valid exactly one cycle after `brIssue`.
- `halt`  input  1  level; stop sequencing.
- `pc`  output  32  current PC.
- `pcValid`  output  1  one-cycle pulse in the cycle after `pc` changes.
- `busy`  output  1  high in BR_WAIT; `step` and `brIssue` are ignored while high.
- `halted`  output  1  high in HALT.
- `takenCount`  output  CNT_W  count of taken branches.
- `notTakenCount`  output  CNT_W  count of not-taken branches.

## Operation
- States:
  - IDLE: after reset.
  - RUN: normal sequencing.
  - BR_WAIT: one cycle, waiting for the comparator decision.
  - HALT: stopped.
- IDLE:
  - `start` moves to RUN; `pc` is unchanged.
  - `step` and `brIssue` are ignored.
- RUN, priority order (highest first):
  1. `halt`: go to HALT.
  2. `brIssue`: capture `brTarget` into `tgtReg` and go to BR_WAIT. This applies even if `step` is also high.
  3. `step`: `pc <= pc + PC_INC`, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- BR_WAIT:
  - Sample `isBranch`.
  - If 1: `pc <= tgtReg` and increment `takenCount`.
  - If 0: `pc <= pc + PC_INC` and increment `notTakenCount`.
  - Always return to RUN.
  - `halt` asserted in BR_WAIT does not cancel the resolution. The branch resolves first and `halt` takes effect from RUN on the next cycle.
- HALT:
  - Absorbing state; only `rst` exits it.
  - `pc` is held.
- `pcValid` is registered: it is high in the cycle after any `pc` update (step or branch resolution), otherwise low.
- A branch resolution counts as a `pc` update even when `tgtReg == pc`. `pcValid` still pulses.

## Timing
- Reset values:
  - state = IDLE
  - `pc` = RESET_PC
  - `tgtReg` = 0
  - `pcValid` = 0
  - `busy` = 0
  - `halted` = 0
  - both counters = 0
- `rst` asserted at any time, including mid BR_WAIT, immediately forces all reset values. The pending branch is discarded.
- Step latency: `step` at edge N gives the new `pc` visible after edge N and `pcValid` high during cycle N+1.
- Branch latency: `brIssue` at edge N gives BR_WAIT during cycle N+1. `isBranch` is sampled at edge N+1, the new `pc` is visible after edge N+1, and `pcValid` is high during cycle N+2. Total: 2 cycles from issue to new PC.
- The earliest back-to-back branch is a `brIssue` accepted at edge N+2.
- `busy` is combinationally equal to (state == BR_WAIT).
- `halted` is combinationally equal to (state == HALT).

## Configuration
- Macro: `NEXT_PC_BRANCH_STATS_EN`.
- Defined:
  - `takenCount` and `notTakenCount` are live.
  - Each saturates at all-ones and never wraps.
  - Both reset to 0.
- Undefined:
  - The counter registers are not built.
  - Both ports are tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `next_pc_pkg`:
  - state enum: IDLE, RUN, BR_WAIT, HALT.
  - default RESET_PC and PC_INC constants.
- Sub-module `sat_counter`:
  - Parameterised width; ports: `clk`, `rst`, `inc`, `count`.
  - Instantiated twice, under the macro only.

## Test plan
- Reset, `start`, three `step` pulses -> `pc` = 0x0, 0x4, 0x8, 0xC; `pcValid` pulses three times.
- In RUN with `pc` = 0x10: `brIssue` with `brTarget` = 0x200, then `isBranch` = 1 -> `busy` high for 1 cycle, `pc` = 0x200 two cycles after issue, `takenCount` = 1.
- With `pc` = 0x10: `brIssue` with `isBranch` = 0 -> `pc` = 0x14, `notTakenCount` = 1. Also `step` and `brIssue` together -> branch path taken, no extra increment.
- `rst` pulsed during BR_WAIT -> `pc` = RESET_PC, state IDLE, counters 0; a following `isBranch` = 1 has no effect.
- Edge cases:
  - `halt` in BR_WAIT -> the branch resolves, then `halted` = 1 one cycle later; subsequent `step` pulses leave `pc` unchanged.
  - `RESET_PC` = 32'hFFFF_FFFC, `start`, `step` -> `pc` = 0.
- With the macro and `CNT_W` = 2: five taken branches -> `takenCount` = 3. Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/next_pc_pkg.sv
// Shared types and defaults for the next-PC sequencing stage.
// Used by next_pc_unit (top) and visible to any block that needs the state names.
package next_pc_pkg;

    // Sequencer states: idle after reset, running, waiting one cycle for the
    // comparator's decision, and the absorbing halted state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        BR_WAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_INC   = 4;

endpackage

// File: rtl/next_pc_unit_sat_counter.sv
// Saturating up-counter used for the taken / not-taken branch statistics.
// Sticks at all-ones instead of wrapping so a long run never reads as a small count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on each increment request until every bit is set, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter sequencer sitting just after the branch comparator.
// Owns the architectural PC, advances it on step, and resolves branches one cycle
// after issue using the comparator's registered isBranch decision.
// Optional statistics counters are built only when NEXT_PC_BRANCH_STATS_EN is defined;
// otherwise takenCount / notTakenCount read constant zero.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_INC   = DEFAULT_PC_INC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             brIssue,
    input  logic [31:0]      brTarget,
    input  logic             isBranch,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic             pcValid,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] takenCount,
    output logic [CNT_W-1:0] notTakenCount
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic        r_pcValid;
    logic [31:0] w_pcNext;

    // Fall-through address; natural 32-bit overflow gives the required wrap to 0.
    assign w_pcNext = r_pc + 32'(PC_INC);

    // Sequencer: halt beats branch issue beats step while running; a pending branch
    // always resolves before a halt can take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_tgt     <= '0;
            r_pcValid <= 1'b0;
        end else begin
            r_pcValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        r_state <= HALT;
                    end else if (brIssue) begin
                        r_tgt   <= brTarget;
                        r_state <= BR_WAIT;
                    end else if (step) begin
                        r_pc      <= w_pcNext;
                        r_pcValid <= 1'b1;
                    end
                end
                BR_WAIT: begin
                    r_pc      <= isBranch ? r_tgt : w_pcNext;
                    r_pcValid <= 1'b1;
                    r_state   <= RUN;
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign pcValid = r_pcValid;
    assign busy    = (r_state == BR_WAIT);
    assign halted  = (r_state == HALT);

`ifdef NEXT_PC_BRANCH_STATS_EN
    logic w_takenInc;
    logic w_notTakenInc;

    assign w_takenInc    = (r_state == BR_WAIT) &&  isBranch;
    assign w_notTakenInc = (r_state == BR_WAIT) && !isBranch;

    sat_counter #(.W(CNT_W)) u_takenCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_takenInc),
        .count (takenCount)
    );

    sat_counter #(.W(CNT_W)) u_notTakenCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_notTakenInc),
        .count (notTakenCount)
    );
`else
    assign takenCount    = '0;
    assign notTakenCount = '0;
`endif

endmodule
